// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 2-of-3 majority bit sampling,
// optional parity and per-frame parity/stop error pulses.
module uart_rx #(
   parameter int DWIDTH = 8
) (
   input  logic              clk_rx,
   input  logic              rst,
   input  logic              rx_in,
   input  logic [5:0]        prescale,
   input  logic              par_en,
   input  logic              par_typ,
   output logic [DWIDTH-1:0] p_data_rx,
   output logic              data_valid_rx,
   output logic              par_err,
   output logic              stp_err
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int BW = $clog2(DWIDTH + 1);
   state_t state, nxt;
   logic s1, rx_s, pe, pt, bad, stp;
   logic [5:0] p, cnt, half;
   logic [BW-1:0] bits;
   logic [1:0] samp;
   logic [DWIDTH-1:0] sh;
   logic last, mid, maj, done, good;
   assign half = {1'b0, p[5:1]};
   assign last = cnt == p - 6'd1;
   assign mid  = cnt == half + 6'd1;
   // third sample is the live rx_s, so the majority is ready on edge P/2+1
   assign maj  = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
   assign done = state == STOP && last;
   assign good = done && stp && !bad;
   always_ff @(posedge clk_rx or negedge rst)
      if (!rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = rx_s ? IDLE : START;
         START:   nxt = (mid && maj) ? IDLE : (last ? DATA : START);
         DATA:    nxt = (last && bits == BW'(DWIDTH - 1)) ? (pe ? PARITY : STOP) : DATA;
         PARITY:  nxt = last ? STOP : PARITY;
         STOP:    nxt = last ? IDLE : STOP;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk_rx or negedge rst)
      if (!rst) begin
         s1 <= 1'b1;
         rx_s <= 1'b1;
         p <= '0;
         pe <= 1'b0;
         pt <= 1'b0;
         cnt <= '0;
         bits <= '0;
         samp <= '0;
         sh <= '0;
         bad <= 1'b0;
         stp <= 1'b0;
         p_data_rx <= '0;
         data_valid_rx <= 1'b0;
         par_err <= 1'b0;
         stp_err <= 1'b0;
      end else begin
         s1 <= rx_in;
         rx_s <= s1;
         data_valid_rx <= good;
         par_err <= done && bad;
         stp_err <= done && !stp;
         if (good) p_data_rx <= sh;
         if (state == IDLE) begin
            // the cycle that first sees the low line is already edge 0
            cnt <= rx_s ? 6'd0 : 6'd1;
            bits <= '0;
            bad <= 1'b0;
            if (!rx_s) begin
               p <= prescale;
               pe <= par_en;
               pt <= par_typ;
            end
         end else begin
            cnt <= (last || nxt == IDLE) ? 6'd0 : cnt + 6'd1;
            if (cnt == half - 6'd1) samp[0] <= rx_s;
            if (cnt == half) samp[1] <= rx_s;
            if (mid && state == DATA) sh <= {maj, sh[DWIDTH-1:1]};
            if (mid && state == PARITY) bad <= maj != ((^sh) ^ pt);
            if (mid && state == STOP) stp <= maj;
            if (state == DATA && last) bits <= bits + 1'b1;
         end
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames feed an expectation queue; a monitor pops and
// checks kind, data and arrival cycle of every output pulse.
module tb_uart_rx;
   logic clk = 0, rst = 0, rx_in = 1, par_en = 0, par_typ = 0;
   logic [5:0] prescale = 6'd8;
   logic [7:0] p_data_rx;
   logic data_valid_rx, par_err, stp_err;
   int cyc = 0, checks = 0, errors = 0;
   logic [7:0] last_good = 8'h00;
   typedef struct {logic [2:0] kind; logic [7:0] data; int at;} exp_t;
   exp_t q[$];

   uart_rx #(.DWIDTH(8)) dut (
      .clk_rx(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
      .par_en(par_en), .par_typ(par_typ), .p_data_rx(p_data_rx),
      .data_valid_rx(data_valid_rx), .par_err(par_err), .stp_err(stp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (data_valid_rx | par_err | stp_err) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse got v%0b p%0b s%0b expected none (cycle %0d)",
                        data_valid_rx, par_err, stp_err, cyc);
            end else begin
               e = q.pop_front();
               chk("pulse_kind", {29'd0, data_valid_rx, par_err, stp_err}, {29'd0, e.kind});
               chk("p_data_rx", {24'd0, p_data_rx}, {24'd0, e.data});
               chk("pulse_cycle", cyc, e.at);
            end
         end
      end
   endtask

   // called at a negedge; returns at the negedge where the next frame may start
   task automatic send(input logic [7:0] d, input int pv, input bit pen, input bit ptyp,
                       input bit flip_par, input bit stop, input int cut);
      logic [10:0] f;
      int n;
      bit pb;
      exp_t e;
      prescale = 6'(pv);
      par_en = pen;
      par_typ = ptyp;
      pb = (^d) ^ ptyp ^ flip_par;
      n = pen ? 11 : 10;
      f = pen ? {stop, pb, d, 1'b0} : {1'b1, stop, d, 1'b0};
      if (cut >= n) begin
         e.kind = {stop && !(pen && flip_par), pen && flip_par, !stop};
         if (e.kind[2]) last_good = d;
         e.data = last_good;
         e.at = cyc + 2 + n * pv;
         q.push_back(e);
      end
      for (int i = 0; i < n && i < cut; i++) begin
         rx_in = f[i];
         repeat (pv) @(negedge clk);
      end
      rx_in = 1;
   endtask

   initial begin
      fork
         monitor();
      join_none
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx_in = i[0];
      end
      chk("rst_p_data", {24'd0, p_data_rx}, 32'd0);
      chk("rst_valid", {31'd0, data_valid_rx}, 32'd0);
      chk("rst_par_err", {31'd0, par_err}, 32'd0);
      chk("rst_stp_err", {31'd0, stp_err}, 32'd0);
      rx_in = 1;
      @(negedge clk);
      rst = 1;
      repeat (100) @(negedge clk);
      send(8'hA5, 8, 0, 0, 0, 1, 99);
      repeat (5) @(negedge clk);
      send(8'h3C, 16, 1, 0, 0, 1, 99);
      repeat (5) @(negedge clk);
      send(8'h3C, 16, 1, 0, 1, 1, 99);
      repeat (5) @(negedge clk);
      send(8'h81, 32, 1, 1, 0, 0, 99);
      repeat (5) @(negedge clk);
      prescale = 6'd16;
      par_en = 0;
      rx_in = 0;
      repeat (2) @(negedge clk);
      rx_in = 1;
      repeat (30) @(negedge clk);
      chk("glitch_idle", int'(dut.state), 32'd0);
      send(8'h55, 16, 0, 0, 0, 1, 99);
      repeat (5) @(negedge clk);
      send(8'h01, 8, 0, 0, 0, 1, 99);
      send(8'hFE, 8, 0, 0, 0, 1, 99);
      send(8'h7E, 8, 0, 0, 0, 1, 99);
      repeat (5) @(negedge clk);
      send(8'h01, 8, 0, 0, 0, 1, 99);
      send(8'hFE, 8, 0, 0, 0, 1, 5);
      rst = 0;
      last_good = 8'h00;
      repeat (3) @(negedge clk);
      chk("midrst_p_data", {24'd0, p_data_rx}, 32'd0);
      rst = 1;
      repeat (10) @(negedge clk);
      send(8'h7E, 8, 0, 0, 0, 1, 99);
      repeat (50) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
